// File: rtl/oam_dma_controller_pkg.sv
// Shared constants and types for the FF46 OAM DMA controller.
// Register address, OAM/echo bases, transfer length and FSM state type.
package oam_dma_controller_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;
   localparam logic [7:0]  ECHO_FOLD    = 8'h20;
   localparam int          OAM_LEN_DEF  = 160;

   typedef enum logic [1:0] {
      IDLE,
      START,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// FF46 OAM DMA engine and CPU/DMA arbiter for the shared main bus.
// Ports: clock/reset, CPU bus (cs, A_cpu, Di_cpu, Do_cpu, rd/wr strobes),
// shared bus (A, Do, Di, rd_n, wr_n), OAM write port, active flag.
module oam_dma_controller
   import oam_dma_controller_pkg::*;
#(
   parameter int READ_CYCLES = 3,
   parameter int OAM_LEN     = OAM_LEN_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cs,
   input  logic [15:0] A_cpu,
   input  logic [7:0]  Di_cpu,
   output logic [7:0]  Do_cpu,
   input  logic        rd_cpu_n,
   input  logic        wr_cpu_n,
   output logic [15:0] A,
   output logic [7:0]  Do,
   input  logic [7:0]  Di,
   output logic        rd_n,
   output logic        wr_n,
   output logic [7:0]  A_oam,
   output logic [7:0]  Do_oam,
   output logic        wr_oam_n,
   output logic        active
);

   localparam int             RW    = $clog2(READ_CYCLES + 1);
   localparam logic [RW-1:0]  RLAST = RW'(READ_CYCLES - 1);
   localparam logic [7:0]     ILAST = 8'(OAM_LEN - 1);

   dma_state_t    state_q, state_d;
   logic [7:0]    src_q, src_d;
   logic [7:0]    idx_q, idx_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          prev_wr_n_q;
   logic          active_q, active_d;
   logic          wr_oam_n_q, wr_oam_n_d;
   logic [7:0]    a_oam_q, a_oam_d;
   logic [7:0]    do_oam_q, do_oam_d;
   logic          wr_start;
   logic [7:0]    eff_src;

   // One trigger per CPU write: only the falling edge of the strobe counts.
   assign wr_start = cs & ~wr_cpu_n & prev_wr_n_q;

   // Sources in echo RAM (E000+) fold down onto work RAM.
   assign eff_src = (src_q >= ECHO_BASE_HI) ? (src_q - ECHO_FOLD) : src_q;

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      idx_d    = idx_q;
      rcnt_d   = rcnt_q;
      a_oam_d  = a_oam_q;
      do_oam_d = do_oam_q;
      if (wr_start) src_d = Di_cpu;
      unique case (state_q)
         IDLE: begin
            if (wr_start) state_d = START;
         end
         START: begin
            idx_d   = 8'd0;
            rcnt_d  = '0;
            state_d = wr_start ? START : READ;
         end
         READ: begin
            // A restart abandons this byte before it reaches OAM.
            if (wr_start) begin
               state_d = START;
            end else if (rcnt_q == RLAST) begin
               do_oam_d = Di;
               a_oam_d  = idx_q;
               state_d  = WRITE;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
            end
         end
         WRITE: begin
            if (wr_start) begin
               state_d = START;
            end else if (idx_q == ILAST) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               rcnt_d  = '0;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
      active_d   = (state_d != IDLE);
      wr_oam_n_d = (state_d != WRITE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         src_q       <= 8'h00;
         idx_q       <= 8'd0;
         rcnt_q      <= '0;
         prev_wr_n_q <= 1'b1;
         active_q    <= 1'b0;
         wr_oam_n_q  <= 1'b1;
         a_oam_q     <= 8'd0;
         do_oam_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         idx_q       <= idx_d;
         rcnt_q      <= rcnt_d;
         prev_wr_n_q <= wr_cpu_n;
         active_q    <= active_d;
         wr_oam_n_q  <= wr_oam_n_d;
         a_oam_q     <= a_oam_d;
         do_oam_q    <= do_oam_d;
      end
   end

   // Bus mux: CPU pass-through when idle (including during reset),
   // DMA-owned otherwise with CPU accesses masked.
   always_comb begin
      if (state_q == IDLE) begin
         A      = A_cpu;
         Do     = Di_cpu;
         rd_n   = rd_cpu_n;
         wr_n   = wr_cpu_n;
         Do_cpu = Di;
      end else begin
         A      = {eff_src, idx_q};
         Do     = 8'h00;
         rd_n   = (state_q != READ);
         wr_n   = 1'b1;
         Do_cpu = 8'hFF;
      end
      if (cs & ~rd_cpu_n) Do_cpu = src_q;
   end

   assign active   = active_q;
   assign wr_oam_n = wr_oam_n_q;
   assign A_oam    = a_oam_q;
   assign Do_oam   = do_oam_q;

endmodule
